flag_packer: RTL and testbench

Read-side companion for the single-bit `flag_fifo`. It drains flags from the FIFO and packs them LSB-first into `WIDTH`-bit words, which it presents on a valid/ready output. It sits directly on the FIFO's pop side. The FIFO has no empty/full outputs, so the block snoops the FIFO's push strobe to keep its own exact occupancy count. A `flush` request emits a partial word.

---
 rtl/flag_packer.sv | 92 +++++++++
 tb/tb_flag_packer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_packer.sv
// Drains single-bit flags from an attached flag_fifo and packs them LSB-first
// into WIDTH-bit words on a valid/ready output; flush emits a partial word.
module flag_packer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_push,
  output logic             pop,
  input  logic             pop_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LEN_W-1:0] out_len
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [LEN_W-1:0] WIDTH_C = LEN_W'(WIDTH);
  localparam logic [LEN_W:0]   WIDTH_X = (LEN_W + 1)'(WIDTH);

  logic [CNT_W-1:0] avail;
  logic [LEN_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic             inflight;
  logic             flush_pend;

  logic push_eff;
  logic slot_free;
  logic xfer;
  logic flush_drop;

  // Pop never coincides with a push, which keeps the occupancy mirror exact;
  // the in-flight bit is counted so the accumulator can never overflow.
  always_comb begin
    push_eff   = fifo_push && (avail != DEPTH_C);
    pop        = (avail != '0) && !fifo_push && !flush_pend &&
                 (({1'b0, cnt} + {{LEN_W{1'b0}}, inflight}) < WIDTH_X);
    slot_free  = !out_valid || out_ready;
    xfer       = slot_free &&
                 ((cnt == WIDTH_C) || (flush_pend && !inflight && (cnt != '0)));
    flush_drop = flush_pend && !inflight && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avail      <= '0;
      cnt        <= '0;
      acc        <= '0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_len    <= '0;
    end else begin
      if (push_eff) begin
        avail <= avail + CNT_W'(1);
      end else if (pop) begin
        avail <= avail - CNT_W'(1);
      end

      inflight <= pop;

      // acc only ever gains bit cnt, so bits at and above cnt stay zero
      if (xfer) begin
        acc <= '0;
        cnt <= '0;
      end else if (inflight) begin
        acc <= acc | (WIDTH'(pop_data) << cnt);
        cnt <= cnt + LEN_W'(1);
      end

      if (flush && !flush_pend) begin
        flush_pend <= 1'b1;
      end else if (xfer || flush_drop) begin
        flush_pend <= 1'b0;
      end

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= acc;
        out_len   <= cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flag_packer.sv
// Bench for flag_packer: behavioural flag_fifo, bit-stream scoreboard checked
// every cycle, and directed scenarios with hand-computed words.
module tb_flag_packer;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_push = 1'b0;
  logic             push_bit = 1'b0;
  logic             pop;
  logic             pop_data = 1'b0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [LEN_W-1:0] out_len;

  int n_vec = 0;
  int n_err = 0;

  bit               fifo_q[$];
  bit               exp_q[$];
  logic [WIDTH-1:0] words[$];
  int               lens[$];

  always #5 clk = ~clk;

  flag_packer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_push (fifo_push),
    .pop       (pop),
    .pop_data  (pop_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // flag_fifo model: pushes while full are dropped, pop_data arrives next cycle
  always @(posedge clk) begin
    if (!rst_n) begin
      fifo_q.delete();
      exp_q.delete();
      pop_data <= 1'b0;
    end else begin
      if (pop && fifo_q.size() > 0) pop_data <= fifo_q.pop_front();
      if (fifo_push && fifo_q.size() < DEPTH) begin
        fifo_q.push_back(push_bit);
        exp_q.push_back(push_bit);
      end
    end
  end

  logic             hold_v = 1'b0;
  logic [WIDTH-1:0] hold_d;
  logic [LEN_W-1:0] hold_l;
  logic [WIDTH-1:0] e_word;
  int               e_n;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      chk("pop_with_push", {31'b0, pop && fifo_push}, 0);
      chk("pop_when_empty", {31'b0, pop && (fifo_q.size() == 0)}, 0);
      chk("avail_mirror", 32'(dut.avail), fifo_q.size());
      if (hold_v) begin
        chk("hold_valid", {31'b0, out_valid}, 1);
        chk("hold_data", 32'(out_data), 32'(hold_d));
        chk("hold_len", 32'(out_len), 32'(hold_l));
      end
      if (out_valid && out_ready) begin
        e_n = int'(out_len);
        e_word = '0;
        chk("len_range", {31'b0, (e_n >= 1) && (e_n <= WIDTH)}, 1);
        for (int i = 0; i < e_n && i < WIDTH; i++) begin
          if (exp_q.size() == 0) chk("stream_underflow", 1, 0);
          else e_word[i] = exp_q.pop_front();
        end
        chk("word_data", 32'(out_data), 32'(e_word));
        words.push_back(out_data);
        lens.push_back(int'(out_len));
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_len;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      fifo_push = 1'b1;
      push_bit  = bits[i];
      tick();
      fifo_push = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (words.size() < target && k < budget) begin
      tick();
      k++;
    end
    chk(name, words.size(), target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int nw;

    // reset state
    rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_valid", {31'b0, out_valid}, 0);
    chk("reset_len", 32'(out_len), 0);
    chk("reset_data", 32'(out_data), 0);
    chk("reset_pop", {31'b0, pop}, 0);
    tick();
    rst_n = 1'b1;

    // full word: 1,0,1,1,0,0,1,0 -> 8'h4D
    out_ready = 1'b1;
    push_seq(32'h4D, 8, 0);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 40) begin
      k++;
      @(negedge clk);
    end
    chk("full_word_latency", k, WIDTH + 2);
    tick();
    wait_words(1, 30, "full_word_count");
    chk("full_word_data", 32'(words[0]), 32'h4D);
    chk("full_word_len", lens[0], 8);

    // flush partial: 1,1,0 -> 8'h03, len 3, valid 2 cycles after flush
    push_seq(32'h3, 3, 0);
    repeat (6) tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_early", {31'b0, out_valid}, 0);
    tick();
    flush = 1'b0;
    k = 1;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("flush_latency", k, 2);
    tick();
    wait_words(2, 20, "flush_word_count");
    chk("flush_data", 32'(words[1]), 32'h03);
    chk("flush_len", lens[1], 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    chk("empty_flush_words", words.size(), 2);

    // backpressure: word held, acc full, FIFO saturates and drops
    out_ready = 1'b0;
    push_seq(32'hA5, 8, 2);
    push_seq(32'h3C, 8, 2);
    repeat (4) tick();
    chk("bp_held_valid", {31'b0, out_valid}, 1);
    chk("bp_held_data", 32'(out_data), 32'hA5);
    chk("bp_held_len", 32'(out_len), 8);
    chk("bp_acc_full", 32'(dut.cnt), 8);
    push_seq(32'hF96, 12, 0);
    repeat (2) tick();
    chk("bp_avail_sat", 32'(dut.avail), 8);
    chk("bp_no_pop", {31'b0, pop}, 0);
    out_ready = 1'b1;
    wait_words(5, 80, "bp_word_count");
    chk("bp_word0", 32'(words[2]), 32'hA5);
    chk("bp_word1", 32'(words[3]), 32'h3C);
    chk("bp_word2", 32'(words[4]), 32'h96);
    chk("bp_word2_len", lens[4], 8);

    // interleaved random push/pop with random backpressure
    for (int i = 0; i < 64;) begin
      fifo_push = ($urandom_range(0, 1) == 1);
      push_bit  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      if (fifo_push) i++;
      tick();
    end
    fifo_push = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    chk("stream_drained", exp_q.size(), 0);

    // reset mid-word with a held word and cnt == 5
    out_ready = 1'b0;
    push_seq(32'h0F0F, 13, 2);
    repeat (3) tick();
    chk("pre_reset_cnt", 32'(dut.cnt), 5);
    chk("pre_reset_valid", {31'b0, out_valid}, 1);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("post_reset_valid", {31'b0, out_valid}, 0);
    chk("post_reset_pop", {31'b0, pop}, 0);
    chk("post_reset_len", 32'(out_len), 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    nw = words.size();
    push_seq(32'h5A, 8, 0);
    wait_words(nw + 1, 40, "after_reset_count");
    chk("after_reset_data", 32'(words[nw]), 32'h5A);
    chk("after_reset_len", lens[nw], 8);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
